// File: rtl/mcdt_fmt_pkg.sv
// Shared types and constants for the mcdt packet formatter: FSM state encoding,
// channel/data widths and the round-robin channel picker.
package mcdt_fmt_pkg;

  localparam int FMT_NUM_CH = 3;
  localparam int FMT_ID_W   = 2;
  localparam int FMT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SEND
  } fmt_state_e;

  // First eligible channel after 'last', wrapping modulo FMT_NUM_CH.
  function automatic logic [FMT_ID_W-1:0] rr_pick(input logic [FMT_ID_W-1:0] last,
                                                  input logic [FMT_NUM_CH-1:0] elig);
    logic [FMT_ID_W-1:0] cand;
    logic [FMT_ID_W-1:0] pick;
    logic                found;
    cand  = last;
    pick  = last;
    found = 1'b0;
    for (int off = 0; off < FMT_NUM_CH; off++) begin
      cand = (cand == FMT_ID_W'(FMT_NUM_CH - 1)) ? '0 : cand + FMT_ID_W'(1);
      if (!found && elig[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mcdt_fmt_fifo.sv
// Per-channel synchronous FIFO with show-ahead read data; a simultaneous write and
// read is accepted even when full because the read frees the slot at the same edge.
module mcdt_fmt_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mcdt_formatter.sv
// Captures the merged mcdt stream into per-channel FIFOs and emits fixed-length packets
// round-robin over a req/grant handshake. Define MCDT_FMT_PARITY_EN to build fmt_parity_o.
module mcdt_formatter
  import mcdt_fmt_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int PKT_LEN    = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [FMT_DATA_W-1:0] mcdt_data_i,
  input  logic                  mcdt_val_i,
  input  logic [FMT_ID_W-1:0]   mcdt_id_i,
  output logic                  fmt_req_o,
  input  logic                  fmt_grant_i,
  output logic [FMT_ID_W-1:0]   fmt_chid_o,
  output logic [7:0]            fmt_length_o,
  output logic                  fmt_start_o,
  output logic                  fmt_end_o,
  output logic [FMT_DATA_W-1:0] fmt_data_o,
  output logic [FMT_NUM_CH-1:0] fmt_ovf_o,
  output logic                  fmt_parity_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fmt_state_e            state;
  logic [7:0]            beat_cnt;
  logic [FMT_ID_W-1:0]   last_served;
  logic [FMT_NUM_CH-1:0] wr_en;
  logic [FMT_NUM_CH-1:0] rd_en;
  logic [FMT_NUM_CH-1:0] full;
  logic [FMT_NUM_CH-1:0] empty;
  logic [FMT_NUM_CH-1:0] elig_now;
  logic [FMT_NUM_CH-1:0] elig_q;
  logic [FMT_NUM_CH-1:0] elig;
  logic [CW-1:0]         cnt     [FMT_NUM_CH];
  logic [FMT_DATA_W-1:0] rd_data [FMT_NUM_CH];
  logic [FMT_DATA_W-1:0] sel_data;

  always_comb begin
    sel_data = '0;
    wr_en    = '0;
    rd_en    = '0;
    elig_now = '0;
    for (int c = 0; c < FMT_NUM_CH; c++) begin
      wr_en[c]    = mcdt_val_i && (mcdt_id_i == FMT_ID_W'(c));
      rd_en[c]    = (state == SEND) && (fmt_chid_o == FMT_ID_W'(c)) && !empty[c];
      elig_now[c] = (cnt[c] >= CW'(PKT_LEN));
      if (fmt_chid_o == FMT_ID_W'(c)) sel_data = rd_data[c];
    end
  end

  // The registered copy gives the one-cycle eligibility latency and, ANDed with the live
  // count, masks the stale flag left over from the pop that ended the previous packet.
  assign elig = elig_q & elig_now;

  for (genvar g = 0; g < FMT_NUM_CH; g++) begin : g_fifo
    mcdt_fmt_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(FMT_DATA_W)
    ) u_fifo (
      .clk    (clk_i),
      .rst_n  (rstn_i),
      .wr_en  (wr_en[g]),
      .wr_data(mcdt_data_i),
      .rd_en  (rd_en[g]),
      .rd_data(rd_data[g]),
      .full   (full[g]),
      .empty  (empty[g]),
      .count  (cnt[g])
    );
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fmt_ovf_o <= '0;
      elig_q    <= '0;
    end else begin
      elig_q <= elig_now;
      for (int c = 0; c < FMT_NUM_CH; c++) begin
        if (wr_en[c] && full[c] && !rd_en[c]) fmt_ovf_o[c] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= IDLE;
      fmt_req_o    <= 1'b0;
      fmt_chid_o   <= '0;
      fmt_length_o <= '0;
      fmt_start_o  <= 1'b0;
      fmt_end_o    <= 1'b0;
      fmt_data_o   <= '0;
      beat_cnt     <= '0;
      last_served  <= FMT_ID_W'(FMT_NUM_CH - 1);
    end else begin
      case (state)
        IDLE: begin
          fmt_start_o <= 1'b0;
          fmt_end_o   <= 1'b0;
          if (|elig) begin
            fmt_chid_o   <= rr_pick(last_served, elig);
            fmt_req_o    <= 1'b1;
            fmt_length_o <= 8'(PKT_LEN);
            state        <= REQ;
          end
        end
        REQ: begin
          if (fmt_grant_i) begin
            fmt_req_o    <= 1'b0;
            fmt_length_o <= '0;
            beat_cnt     <= '0;
            state        <= SEND;
          end
        end
        SEND: begin
          fmt_data_o  <= sel_data;
          fmt_start_o <= (beat_cnt == 8'd0);
          fmt_end_o   <= (beat_cnt == 8'(PKT_LEN - 1));
          beat_cnt    <= beat_cnt + 8'd1;
          if (beat_cnt == 8'(PKT_LEN - 1)) begin
            last_served <= fmt_chid_o;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MCDT_FMT_PARITY_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)            fmt_parity_o <= 1'b0;
    else if (state == SEND) fmt_parity_o <= ^sel_data;
    else                    fmt_parity_o <= 1'b0;
  end
`else
  assign fmt_parity_o = 1'b0;
`endif

endmodule

// File: tb/tb_mcdt_formatter.sv
// Self-checking bench for mcdt_formatter: random data checked against per-channel
// queues, a round-robin rule model and the documented handshake timing.
module tb_mcdt_formatter;

  localparam int FIFO_DEPTH = 32;
  localparam int PKT_LEN    = 8;

  logic        clk;
  logic        rstn_i;
  logic [31:0] mcdt_data_i;
  logic        mcdt_val_i;
  logic [1:0]  mcdt_id_i;
  logic        fmt_req_o;
  logic        fmt_grant_i;
  logic [1:0]  fmt_chid_o;
  logic [7:0]  fmt_length_o;
  logic        fmt_start_o;
  logic        fmt_end_o;
  logic [31:0] fmt_data_o;
  logic [2:0]  fmt_ovf_o;
  logic        fmt_parity_o;

  int          n_checks;
  int          n_fail;
  logic [31:0] mq [3][$];
  logic [2:0]  ovf_exp;
  int          last_exp;
  int          pkt_ch;
  int          pkt_len;
  int          pkt_err;
  int          pkt_to;
  logic [31:0] pkt_beats [PKT_LEN];
  logic [31:0] exp_beats [PKT_LEN];

  mcdt_formatter #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .PKT_LEN   (PKT_LEN)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .mcdt_data_i (mcdt_data_i),
    .mcdt_val_i  (mcdt_val_i),
    .mcdt_id_i   (mcdt_id_i),
    .fmt_req_o   (fmt_req_o),
    .fmt_grant_i (fmt_grant_i),
    .fmt_chid_o  (fmt_chid_o),
    .fmt_length_o(fmt_length_o),
    .fmt_start_o (fmt_start_o),
    .fmt_end_o   (fmt_end_o),
    .fmt_data_o  (fmt_data_o),
    .fmt_ovf_o   (fmt_ovf_o),
    .fmt_parity_o(fmt_parity_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    for (int c = 0; c < 3; c++) mq[c].delete();
    ovf_exp  = 3'b000;
    last_exp = 2;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  // Drives one word for one cycle and applies the capture rules to the model.
  task automatic write_word(input int ch, input logic [31:0] d);
    mcdt_val_i  = 1'b1;
    mcdt_id_i   = ch[1:0];
    mcdt_data_i = d;
    @(negedge clk);
    mcdt_val_i = 1'b0;
    if (ch < 3) begin
      if (mq[ch].size() < FIFO_DEPTH) mq[ch].push_back(d);
      else ovf_exp[ch] = 1'b1;
    end
  endtask

  function automatic int model_pick();
    int c;
    for (int off = 1; off <= 3; off++) begin
      c = (last_exp + off) % 3;
      if (mq[c].size() >= PKT_LEN) return c;
    end
    return -1;
  endfunction

  task automatic pop_expected(input int ch);
    for (int k = 0; k < PKT_LEN; k++)
      exp_beats[k] = (ch >= 0 && mq[ch].size() > 0) ? mq[ch].pop_front() : 32'hDEAD_BEEF;
    if (ch >= 0) last_exp = ch;
  endtask

  // Waits for a request, stalls the grant, then records one packet and counts protocol slips.
  task automatic collect_packet(input int grant_wait);
    int          waited;
    logic [31:0] held;
    pkt_err = 0;
    pkt_to  = 0;
    pkt_ch  = -1;
    pkt_len = 0;
    waited  = 0;
    while (fmt_req_o !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (fmt_req_o !== 1'b1) begin
      pkt_to = 1;
      return;
    end
    pkt_ch  = int'(fmt_chid_o);
    pkt_len = int'(fmt_length_o);
    held    = fmt_data_o;
    for (int i = 0; i < grant_wait; i++) begin
      @(negedge clk);
      if (fmt_req_o !== 1'b1 || fmt_chid_o !== pkt_ch[1:0] || fmt_start_o !== 1'b0 ||
          fmt_end_o !== 1'b0 || fmt_data_o !== held) pkt_err++;
    end
    fmt_grant_i = 1'b1;
    @(negedge clk);
    fmt_grant_i = 1'b0;
    if (fmt_req_o !== 1'b0 || fmt_start_o !== 1'b0 || fmt_end_o !== 1'b0) pkt_err++;
    for (int k = 0; k < PKT_LEN; k++) begin
      @(negedge clk);
      pkt_beats[k] = fmt_data_o;
      if (fmt_start_o !== (k == 0) || fmt_end_o !== (k == PKT_LEN - 1) ||
          fmt_chid_o !== pkt_ch[1:0]) pkt_err++;
`ifdef MCDT_FMT_PARITY_EN
      if (fmt_parity_o !== ^pkt_beats[k]) pkt_err++;
`else
      if (fmt_parity_o !== 1'b0) pkt_err++;
`endif
    end
    @(negedge clk);
    if (fmt_start_o !== 1'b0 || fmt_end_o !== 1'b0 || fmt_data_o !== pkt_beats[PKT_LEN-1] ||
        fmt_parity_o !== 1'b0) pkt_err++;
  endtask

  task automatic test_reset();
    fmt_grant_i = 1'b0;
    mcdt_val_i  = 1'b0;
    mcdt_id_i   = 2'd0;
    mcdt_data_i = 32'd0;
    rstn_i      = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({fmt_req_o, fmt_start_o, fmt_end_o, fmt_parity_o} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got req/start/end/par=%b required 0000",
               {fmt_req_o, fmt_start_o, fmt_end_o, fmt_parity_o});
    end
    n_checks++;
    if (fmt_data_o !== 32'd0 || fmt_chid_o !== 2'd0 || fmt_length_o !== 8'd0 || fmt_ovf_o !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL reset_data: got data=%h chid=%0d len=%0d ovf=%b required all 0",
               fmt_data_o, fmt_chid_o, fmt_length_o, fmt_ovf_o);
    end
    rstn_i = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (fmt_req_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: got req=%b required 0", fmt_req_o);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < PKT_LEN; i++) write_word(0, 32'(i));
    n_checks++;
    if (fmt_req_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL req_latency_n: got req=%b required 0", fmt_req_o);
    end
    @(negedge clk);
    n_checks++;
    if (fmt_req_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL req_latency_n1: got req=%b required 0", fmt_req_o);
    end
    @(negedge clk);
    n_checks++;
    if (fmt_req_o !== 1'b1 || fmt_length_o !== 8'(PKT_LEN)) begin
      n_fail++;
      $display("[TB] FAIL req_latency_n2: got req=%b len=%0d required 1 and %0d",
               fmt_req_o, fmt_length_o, PKT_LEN);
    end
    pop_expected(model_pick());
    collect_packet(0);
    n_checks++;
    if (pkt_to !== 0 || pkt_ch !== 0 || pkt_err !== 0) begin
      n_fail++;
      $display("[TB] FAIL basic_pkt: got timeout=%0d chid=%0d protocol_errs=%0d required 0,0,0",
               pkt_to, pkt_ch, pkt_err);
    end
    for (int k = 0; k < PKT_LEN; k++) begin
      n_checks++;
      if (pkt_beats[k] !== exp_beats[k]) begin
        n_fail++;
        $display("[TB] FAIL basic_beat%0d: got %h required %h", k, pkt_beats[k], exp_beats[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_ch;
    int order2 [2];
    do_reset();
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < PKT_LEN - 1; i++) write_word(c, $urandom);
    for (int c = 0; c < 3; c++) write_word(c, $urandom);
    for (int p = 0; p < 3; p++) begin
      exp_ch = model_pick();
      pop_expected(exp_ch);
      collect_packet(int'($urandom_range(0, 3)));
      n_checks++;
      if (pkt_to !== 0 || pkt_ch !== exp_ch || pkt_len !== PKT_LEN || pkt_err !== 0) begin
        n_fail++;
        $display("[TB] FAIL rr1_pkt%0d: got to=%0d chid=%0d len=%0d errs=%0d required 0,%0d,%0d,0",
                 p, pkt_to, pkt_ch, pkt_len, pkt_err, exp_ch, PKT_LEN);
      end
      for (int k = 0; k < PKT_LEN; k++) begin
        n_checks++;
        if (pkt_beats[k] !== exp_beats[k]) begin
          n_fail++;
          $display("[TB] FAIL rr1_pkt%0d_beat%0d: got %h required %h", p, k, pkt_beats[k], exp_beats[k]);
        end
      end
    end
    order2[0] = 0;
    order2[1] = 2;
    for (int i = 0; i < PKT_LEN - 1; i++) write_word(2, $urandom);
    for (int i = 0; i < PKT_LEN - 1; i++) write_word(0, $urandom);
    write_word(0, $urandom);
    write_word(2, $urandom);
    for (int p = 0; p < 2; p++) begin
      exp_ch = model_pick();
      pop_expected(exp_ch);
      collect_packet(int'($urandom_range(0, 3)));
      n_checks++;
      if (pkt_to !== 0 || pkt_ch !== exp_ch || pkt_ch !== order2[p] || pkt_err !== 0) begin
        n_fail++;
        $display("[TB] FAIL rr2_pkt%0d: got to=%0d chid=%0d errs=%0d required 0,%0d,0",
                 p, pkt_to, pkt_ch, pkt_err, order2[p]);
      end
      for (int k = 0; k < PKT_LEN; k++) begin
        n_checks++;
        if (pkt_beats[k] !== exp_beats[k]) begin
          n_fail++;
          $display("[TB] FAIL rr2_pkt%0d_beat%0d: got %h required %h", p, k, pkt_beats[k], exp_beats[k]);
        end
      end
    end
  endtask

  task automatic test_grant_stall();
    int exp_ch;
    for (int i = 0; i < PKT_LEN; i++) write_word(1, $urandom);
    exp_ch = model_pick();
    pop_expected(exp_ch);
    collect_packet(20);
    n_checks++;
    if (pkt_to !== 0 || pkt_ch !== exp_ch || pkt_err !== 0) begin
      n_fail++;
      $display("[TB] FAIL stall_pkt: got to=%0d chid=%0d errs=%0d required 0,%0d,0",
               pkt_to, pkt_ch, pkt_err, exp_ch);
    end
    for (int k = 0; k < PKT_LEN; k++) begin
      n_checks++;
      if (pkt_beats[k] !== exp_beats[k]) begin
        n_fail++;
        $display("[TB] FAIL stall_beat%0d: got %h required %h", k, pkt_beats[k], exp_beats[k]);
      end
    end
  endtask

  task automatic test_overflow();
    int exp_ch;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) write_word(1, $urandom);
    write_word(3, $urandom);
    n_checks++;
    if (fmt_ovf_o !== ovf_exp || fmt_ovf_o !== 3'b010) begin
      n_fail++;
      $display("[TB] FAIL ovf_flag: got %b required %b", fmt_ovf_o, ovf_exp);
    end
    for (int p = 0; p < FIFO_DEPTH / PKT_LEN; p++) begin
      exp_ch = model_pick();
      pop_expected(exp_ch);
      collect_packet(int'($urandom_range(0, 2)));
      n_checks++;
      if (pkt_to !== 0 || pkt_ch !== exp_ch || pkt_err !== 0) begin
        n_fail++;
        $display("[TB] FAIL ovf_pkt%0d: got to=%0d chid=%0d errs=%0d required 0,%0d,0",
                 p, pkt_to, pkt_ch, pkt_err, exp_ch);
      end
      for (int k = 0; k < PKT_LEN; k++) begin
        n_checks++;
        if (pkt_beats[k] !== exp_beats[k]) begin
          n_fail++;
          $display("[TB] FAIL ovf_pkt%0d_beat%0d: got %h required %h", p, k, pkt_beats[k], exp_beats[k]);
        end
      end
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (fmt_req_o !== 1'b0 || fmt_ovf_o !== ovf_exp) begin
      n_fail++;
      $display("[TB] FAIL ovf_drained: got req=%b ovf=%b required 0 and %b", fmt_req_o, fmt_ovf_o, ovf_exp);
    end
  endtask

  task automatic test_concurrent();
    logic [31:0] base;
    logic [31:0] got_q [$];
    int          n_words;
    base    = $urandom;
    n_words = 3 * PKT_LEN;
    fork
      begin
        for (int i = 0; i < n_words; i++) begin
          mcdt_val_i  = 1'b1;
          mcdt_id_i   = 2'd0;
          mcdt_data_i = base + 32'(i);
          @(negedge clk);
        end
        mcdt_val_i = 1'b0;
      end
      begin
        for (int p = 0; p < 3; p++) begin
          collect_packet(0);
          n_checks++;
          if (pkt_to !== 0 || pkt_ch !== 0 || pkt_err !== 0) begin
            n_fail++;
            $display("[TB] FAIL conc_pkt%0d: got to=%0d chid=%0d errs=%0d required 0,0,0",
                     p, pkt_to, pkt_ch, pkt_err);
          end
          if (pkt_to == 0)
            for (int k = 0; k < PKT_LEN; k++) got_q.push_back(pkt_beats[k]);
        end
      end
    join
    last_exp = 0;
    n_checks++;
    if (got_q.size() != n_words || fmt_ovf_o !== ovf_exp) begin
      n_fail++;
      $display("[TB] FAIL conc_count: got words=%0d ovf=%b required %0d and %b",
               got_q.size(), fmt_ovf_o, n_words, ovf_exp);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== base + 32'(i)) begin
        n_fail++;
        $display("[TB] FAIL conc_word%0d: got %h required %h", i, got_q[i], base + 32'(i));
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    int waited;
    int exp_ch;
    for (int i = 0; i < PKT_LEN; i++) write_word(2, $urandom);
    exp_ch = model_pick();
    pop_expected(exp_ch);
    waited = 0;
    while (fmt_req_o !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    fmt_grant_i = 1'b1;
    @(negedge clk);
    fmt_grant_i = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (fmt_data_o !== exp_beats[3] || fmt_chid_o !== 2'd2) begin
      n_fail++;
      $display("[TB] FAIL midpkt_beat3: got data=%h chid=%0d required %h and 2",
               fmt_data_o, fmt_chid_o, exp_beats[3]);
    end
    rstn_i = 1'b0;
    #1;
    n_checks++;
    if ({fmt_req_o, fmt_start_o, fmt_end_o, fmt_parity_o} !== 4'b0000 || fmt_data_o !== 32'd0 ||
        fmt_chid_o !== 2'd0 || fmt_length_o !== 8'd0 || fmt_ovf_o !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got req=%b start=%b end=%b data=%h chid=%0d ovf=%b required all 0",
               fmt_req_o, fmt_start_o, fmt_end_o, fmt_data_o, fmt_chid_o, fmt_ovf_o);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    @(negedge clk);
    for (int i = 0; i < PKT_LEN; i++) write_word(2, $urandom);
    exp_ch = model_pick();
    pop_expected(exp_ch);
    collect_packet(1);
    n_checks++;
    if (pkt_to !== 0 || pkt_ch !== exp_ch || pkt_err !== 0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_pkt: got to=%0d chid=%0d errs=%0d required 0,%0d,0",
               pkt_to, pkt_ch, pkt_err, exp_ch);
    end
    for (int k = 0; k < PKT_LEN; k++) begin
      n_checks++;
      if (pkt_beats[k] !== exp_beats[k]) begin
        n_fail++;
        $display("[TB] FAIL post_reset_beat%0d: got %h required %h", k, pkt_beats[k], exp_beats[k]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_round_robin();
    test_grant_stall();
    test_overflow();
    test_concurrent();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
